wb_stream_arbiter: RTL and testbench

- Shares one Wishbone memory port between NUM_MASTERS streamer DMA masters, e.g. stream writer/reader control units.
- Uses round-robin arbitration with cycle-granular grants. A grant is held for the whole CYC assertion, so classic and incrementing bursts (CTI 010) are never split.
- Contains a per-transfer watchdog that terminates a hung slave access with ERR to the owning master.
- Sits between the streamer masters and the system interconnect.

---
 rtl/wb_stream_pkg.sv | 15 +
 rtl/wb_arb_rr_sel.sv | 23 ++
 rtl/wb_stream_arbiter.sv | 101 ++++++++++
 tb/tb_wb_stream_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stream_pkg.sv
// wb_stream_pkg: shared Wishbone constants, arbiter states and width helper
package wb_stream_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4 = 2'b01;
  localparam logic [1:0] BTE_WRAP8 = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_arb_rr_sel.sv
// wb_arb_rr_sel: combinational round-robin pick of the first requester after last_i
module wb_arb_rr_sel
  import wb_stream_pkg::*;
#(
  parameter int N = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  logic [N-1:0] rot;
  int off;
  // rotate so bit 0 is the master just after last_i, then take the lowest set bit
  always_comb begin
    rot = N'({req_i, req_i} >> (int'(last_i) + 1));
    off = 0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? k : off;
    idx_o = IW'((int'(last_i) + 1 + off) % N);
    valid_o = |req_i;
  end
endmodule

// File: rtl/wb_stream_arbiter.sv
// wb_stream_arbiter: round-robin Wishbone arbiter with cycle-granular grants and a stall watchdog
module wb_stream_arbiter
  import wb_stream_pkg::*;
#(
  parameter int WB_DW = 32,
  parameter int WB_AW = 32,
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS*WB_AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*WB_DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*WB_DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]         wbm_we_i,
  input  logic [NUM_MASTERS-1:0]         wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]         wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]       wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]       wbm_bte_i,
  output logic [WB_DW-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]         wbm_ack_o,
  output logic [NUM_MASTERS-1:0]         wbm_err_o,
  output logic [NUM_MASTERS-1:0]         wbm_rty_o,
  output logic [WB_AW-1:0]               wbs_adr_o,
  output logic [WB_DW-1:0]               wbs_dat_o,
  output logic [WB_DW/8-1:0]             wbs_sel_o,
  output logic                           wbs_we_o,
  output logic                           wbs_cyc_o,
  output logic                           wbs_stb_o,
  output logic [2:0]                     wbs_cti_o,
  output logic [1:0]                     wbs_bte_o,
  input  logic [WB_DW-1:0]               wbs_dat_i,
  input  logic                           wbs_ack_i,
  input  logic                           wbs_err_i,
  input  logic                           wbs_rty_i,
  output logic [NUM_MASTERS-1:0]         grant_o,
  output logic                           timeout_o
);
  localparam int IW = idx_w(NUM_MASTERS);
  localparam int WW = idx_w(TIMEOUT + 1);
  localparam int SW = WB_DW / 8;
  localparam logic [WW-1:0] WD_MAX = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  arb_state_e state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d, last_q, last_d, sel_idx;
  logic [WW-1:0] wd_q, wd_d;
  logic [NUM_MASTERS-1:0] owner;
  logic sel_vld, busy, stb_raw, resp, expire;

  wb_arb_rr_sel #(.N(NUM_MASTERS), .IW(IW)) u_sel (
    .req_i(wbm_cyc_i),
    .last_i(last_q),
    .idx_o(sel_idx),
    .valid_o(sel_vld)
  );

  // route the owner's request to the slave and the slave's response back to the owner only
  always_comb begin
    busy = state_q == ARB_BUSY;
    owner = busy ? NUM_MASTERS'(1) << gnt_q : '0;
    resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    stb_raw = busy & wbm_cyc_i[gnt_q] & wbm_stb_i[gnt_q];
    expire = (TIMEOUT > 0) && stb_raw && !resp && wd_q == WD_MAX;
    wbs_adr_o = busy ? wbm_adr_i[int'(gnt_q)*WB_AW +: WB_AW] : '0;
    wbs_dat_o = busy ? wbm_dat_i[int'(gnt_q)*WB_DW +: WB_DW] : '0;
    wbs_sel_o = busy ? wbm_sel_i[int'(gnt_q)*SW +: SW] : '0;
    wbs_cti_o = busy ? wbm_cti_i[int'(gnt_q)*3 +: 3] : '0;
    wbs_bte_o = busy ? wbm_bte_i[int'(gnt_q)*2 +: 2] : '0;
    wbs_we_o = busy & wbm_we_i[gnt_q];
    wbs_cyc_o = busy & wbm_cyc_i[gnt_q];
    wbs_stb_o = stb_raw & ~expire;
    wbm_dat_o = wbs_dat_i;
    wbm_ack_o = wbs_ack_i ? owner : '0;
    wbm_err_o = (wbs_err_i | expire) ? owner : '0;
    wbm_rty_o = wbs_rty_i ? owner : '0;
    grant_o = owner;
    timeout_o = expire;
  end

  // grant in IDLE, release only when the owner drops cyc; watchdog counts unanswered strobes
  always_comb begin
    state_d = busy ? (wbm_cyc_i[gnt_q] ? ARB_BUSY : ARB_IDLE) : (sel_vld ? ARB_BUSY : ARB_IDLE);
    gnt_d = (!busy && sel_vld) ? sel_idx : gnt_q;
    last_d = (busy && !wbm_cyc_i[gnt_q]) ? gnt_q : last_q;
    wd_d = (TIMEOUT > 0 && stb_raw && !resp && !expire) ? wd_q + 1'b1 : '0;
  end

  // state registers; last_q resets to the top index so master 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q <= '0;
      last_q <= IW'(NUM_MASTERS - 1);
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      wd_q <= wd_d;
    end
  end
endmodule

// File: tb/tb_wb_stream_arbiter.sv
// tb_wb_stream_arbiter: vector table, corner sequences and a random run against a reference model
module tb_wb_stream_arbiter;
  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  typedef struct packed {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic ack;
    logic err;
    logic rty;
    logic [10:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*DW/8-1:0] wbm_sel_i;
  logic [N-1:0] wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [N*3-1:0] wbm_cti_i;
  logic [N*2-1:0] wbm_bte_i;
  logic [DW-1:0] wbm_dat_o;
  logic [N-1:0] wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_o;
  logic [DW/8-1:0] wbs_sel_o;
  logic wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0] wbs_cti_o;
  logic [1:0] wbs_bte_o;
  logic [DW-1:0] wbs_dat_i;
  logic wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [N-1:0] grant_o;
  logic timeout_o;
  int compared = 0;
  int mismatched = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  wb_stream_arbiter #(.WB_DW(DW), .WB_AW(AW), .NUM_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] c, input logic [1:0] s, input logic a, input logic e, input logic r);
    wbm_cyc_i = c;
    wbm_stb_i = s;
    wbs_ack_i = a;
    wbs_err_i = e;
    wbs_rty_i = r;
  endtask

  function automatic logic [10:0] outs();
    return {grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o};
  endfunction

  function automatic vec_t mk(input logic [1:0] c, input logic [1:0] s, input logic a, input logic e,
                              input logic r, input logic [1:0] g, input logic sc, input logic ss,
                              input logic [1:0] ma, input logic [1:0] me, input logic [1:0] mr,
                              input logic to);
    return {c, s, a, e, r, g, sc, ss, ma, me, mr, to};
  endfunction

  initial begin
    int owner, last, run;
    logic busy_m, sr, ex, a, e, r, bad;
    logic [N-1:0] g, c, s;
    logic [AW-1:0] ea;
    wbm_adr_i = {32'h2000, 32'h1000};
    wbm_dat_i = {32'hBBBB_0001, 32'hAAAA_0000};
    wbm_sel_i = '1;
    wbm_we_i = '0;
    wbm_cti_i = {3'b010, 3'b010};
    wbm_bte_i = '0;
    wbs_dat_i = 32'h1234_5678;
    drv(2'b00, 2'b00, '0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // cycle-by-cycle table: single owner, contention, err/rty routing, watchdog expiry, dead cycles
    vq.push_back(mk(2'b00, 2'b00, '0, '0, '0, 2'b00, '0, '0, 2'b00, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b01, 2'b01, '1, '0, '0, 2'b00, '0, '0, 2'b00, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b01, 2'b11, '1, '0, '0, 2'b01, '1, '1, 2'b01, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b01, 2'b01, '1, '0, '0, 2'b01, '1, '1, 2'b01, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b11, 2'b11, '1, '0, '0, 2'b01, '1, '1, 2'b01, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b11, 2'b11, '0, '0, '1, 2'b01, '1, '1, 2'b00, 2'b00, 2'b01, '0));
    vq.push_back(mk(2'b10, 2'b10, '0, '0, '0, 2'b01, '0, '0, 2'b00, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b10, 2'b10, '0, '0, '0, 2'b00, '0, '0, 2'b00, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b10, 2'b10, '1, '0, '0, 2'b10, '1, '1, 2'b10, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b10, 2'b10, '0, '1, '0, 2'b10, '1, '1, 2'b00, 2'b10, 2'b00, '0));
    for (int i = 0; i < TO - 1; i++)
      vq.push_back(mk(2'b10, 2'b10, '0, '0, '0, 2'b10, '1, '1, 2'b00, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b10, 2'b10, '0, '0, '0, 2'b10, '1, '0, 2'b00, 2'b10, 2'b00, '1));
    vq.push_back(mk(2'b10, 2'b10, '0, '0, '0, 2'b10, '1, '1, 2'b00, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b00, 2'b00, '0, '0, '0, 2'b10, '0, '0, 2'b00, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b11, 2'b11, '0, '0, '0, 2'b00, '0, '0, 2'b00, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b11, 2'b11, '1, '0, '0, 2'b01, '1, '1, 2'b01, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b10, 2'b10, '0, '0, '0, 2'b01, '0, '0, 2'b00, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b10, 2'b10, '0, '0, '0, 2'b00, '0, '0, 2'b00, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b10, 2'b10, '1, '0, '0, 2'b10, '1, '1, 2'b10, 2'b00, 2'b00, '0));
    vq.push_back(mk(2'b00, 2'b00, '0, '0, '0, 2'b10, '0, '0, 2'b00, 2'b00, 2'b00, '0));
    for (int i = 0; i < vq.size(); i++) begin
      drv(vq[i].cyc, vq[i].stb, vq[i].ack, vq[i].err, vq[i].rty);
      #3;
      check($sformatf("vec%0d", i), outs(), vq[i].exp);
      tick();
    end
    // watchdog: an ack on the 8th stalled strobe cycle wins over expiry
    drv(2'b01, 2'b01, '0, '0, '0);
    tick();
    bad = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      #3;
      bad |= (wbm_err_o != 2'b00) || timeout_o || !wbs_stb_o;
      tick();
    end
    check("wd_stall_quiet", bad, 1'b0);
    drv(2'b01, 2'b01, '1, '0, '0);
    #3;
    check("wd_ack_beat8", {wbm_ack_o, wbm_err_o, timeout_o, wbs_stb_o}, {2'b01, 2'b00, 1'b0, 1'b1});
    tick();
    drv(2'b00, 2'b00, '0, '0, '0);
    tick();
    tick();
    // burst integrity: master 1 requests at beat 5 of master 0's 16-beat burst
    drv(2'b01, 2'b01, '0, '0, '0);
    tick();
    bad = 1'b0;
    for (int b = 0; b < 16; b++) begin
      wbm_adr_i[AW-1:0] = 32'h1000 + 32'(4 * b);
      wbm_cti_i[2:0] = (b == 15) ? 3'b111 : 3'b010;
      drv((b >= 5) ? 2'b11 : 2'b01, (b >= 5) ? 2'b11 : 2'b01, '1, '0, '0);
      #3;
      bad |= (grant_o != 2'b01) || (wbm_ack_o != 2'b01) || (wbs_adr_o != 32'h1000 + 32'(4 * b))
             || (wbs_cti_o != ((b == 15) ? 3'b111 : 3'b010));
      tick();
    end
    check("burst16_hold", bad, 1'b0);
    drv(2'b10, 2'b10, '0, '0, '0);
    #3;
    check("burst_release", {grant_o, wbs_cyc_o}, {2'b01, 1'b0});
    tick();
    #3;
    check("dead_cycle", {grant_o, wbs_cyc_o}, {2'b00, 1'b0});
    tick();
    #3;
    check("m1_grant", {grant_o, wbs_cyc_o, wbs_adr_o}, {2'b10, 1'b1, 32'h2000});
    tick();
    // reset mid-burst of master 1 while last owner was master 0
    drv(2'b00, 2'b00, '0, '0, '0);
    tick();
    drv(2'b01, 2'b01, '0, '0, '0);
    tick();
    drv(2'b01, 2'b01, '1, '0, '0);
    tick();
    drv(2'b00, 2'b00, '0, '0, '0);
    tick();
    drv(2'b10, 2'b10, '0, '0, '0);
    tick();
    drv(2'b10, 2'b10, '1, '0, '0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    #3;
    check("reset_midburst", {grant_o, wbs_cyc_o, wbs_stb_o, wbs_adr_o}, {2'b00, 1'b0, 1'b0, 32'h0});
    rst = 1'b0;
    drv(2'b11, 2'b11, '0, '0, '0);
    tick();
    #3;
    check("rr_after_reset", grant_o, 2'b01);
    tick();
    drv(2'b00, 2'b00, '0, '0, '0);
    tick();
    // random traffic against a reference model
    owner = -1;
    last = N - 1;
    run = 0;
    c = '0;
    for (int t = 0; t < 3000; t++) begin
      rst = (t == 0) || ($urandom_range(299) == 0);
      for (int m = 0; m < N; m++) begin
        c[m] = c[m] ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
        s[m] = c[m] && ($urandom_range(3) != 0);
      end
      wbm_cyc_i = c;
      wbm_stb_i = s | (N'($urandom) & ~c);
      wbm_adr_i = {$urandom, $urandom};
      wbm_cti_i = 6'($urandom);
      a = $urandom_range(3) == 0;
      e = !a && ($urandom_range(15) == 0);
      r = !a && !e && ($urandom_range(15) == 0);
      wbs_ack_i = a;
      wbs_err_i = e;
      wbs_rty_i = r;
      #3;
      busy_m = owner >= 0;
      g = busy_m ? N'(1) << owner : '0;
      sr = busy_m ? (c[owner] && s[owner]) : 1'b0;
      ex = sr && !(a || e || r) && (run == TO - 1);
      ea = busy_m ? wbm_adr_i[owner*AW +: AW] : '0;
      if (t > 0)
        check($sformatf("rand%0d", t), {outs(), wbs_adr_o},
              {g, busy_m && c[owner], sr && !ex, g & {N{a}}, g & {N{e || ex}}, g & {N{r}}, ex, ea});
      if (rst) begin
        owner = -1;
        last = N - 1;
        run = 0;
      end else begin
        run = (sr && !(a || e || r) && !ex) ? run + 1 : 0;
        if (!busy_m) begin
          for (int k = N; k >= 1; k--) if (c[(last + k) % N]) owner = (last + k) % N;
        end else if (!c[owner]) begin
          last = owner;
          owner = -1;
        end
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
